rvfifo_w6: RTL
==============

RVFIFO_W6 -- requirements
Module: rvfifo_w6

Interface
REQ-001 SHALL have parameter WIDTH, default 6, giving the payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the entry count (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port push, input, 1, write request.
REQ-006 SHALL have port din, input, WIDTH, write data, sampled with push.
REQ-007 SHALL have port pop, input, 1, read request.
REQ-008 SHALL have port dout, output, WIDTH, head entry (first-word fall-through), feeding the downstream WIDTH-bit holding register.
REQ-009 SHALL have port empty, output, 1, high when the entry count is 0.
REQ-010 SHALL have port full, output, 1, high when the entry count is DEPTH.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1, current entry count.
REQ-012 SHALL have ports err_ovf and err_unf, output, 1 each, sticky overflow and underflow flags.

Function
REQ-013 SHALL accept a push iff push=1 and full=0; the FIFO writes din at wr_ptr and increments wr_ptr modulo DEPTH.
REQ-014 SHALL accept a pop iff pop=1 and empty=0; the FIFO increments rd_ptr modulo DEPTH.
REQ-015 SHALL drive dout combinationally from storage[rd_ptr] at all times; when empty=1, dout SHALL hold the stale entry and is not qualified.
REQ-016 SHALL update count as count + accepted_push - accepted_pop each cycle; it never exceeds DEPTH and never goes below 0.
REQ-017 SHALL make pushed data visible on dout in the cycle after the accepting edge when the FIFO was empty; there is no same-cycle bypass.
REQ-018 SHALL, when empty and push=pop=1, accept only the push; count goes to 1.
REQ-019 SHALL, when full and push=pop=1, accept only the pop; the push is dropped and count goes to DEPTH-1.
REQ-020 SHALL, when neither empty nor full and push=pop=1, accept both; count is unchanged and order is preserved.
REQ-021 SHALL wrap both pointers from DEPTH-1 to 0 without a gap or duplicate entry.
REQ-022 SHALL derive empty and full from count only; they are registered-state outputs with no combinational path from push or pop.

Reset
REQ-023 SHALL, while rst=1, force the following asynchronously: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, err_ovf=0, err_unf=0, all storage entries 0, and therefore dout=0.
REQ-024 SHALL discard all contents on a rst assertion mid-operation; the first push after deassertion lands in entry 0.

Configuration
REQ-025 SHALL, with macro RVFIFO_W6_ERR_EN defined, set err_ovf on any edge where push=1 and full=1, and set err_unf on any edge where pop=1 and empty=1; both flags stay high until rst.
REQ-026 SHALL, without RVFIFO_W6_ERR_EN, keep the err_ovf and err_unf ports and tie them to 0, with no flag flops present.

Structure
REQ-027 SHALL take the package rvfifo_pkg as the home for RVFIFO_DEPTH_DEF, RVFIFO_WIDTH_DEF and the pointer-width function/typedef ptr_t.
REQ-028 SHALL implement pointer increment and wrap in one sub-module, rvfifo_ptr, instantiated twice (write and read).
REQ-029 SHALL implement storage as DEPTH WIDTH-bit flop registers with asynchronous reset; no RAM macro is used.

Verification
REQ-030 SHALL cover reset-then-fill: after reset, push 0x01,0x02,0x03,0x04 on consecutive cycles -> full=1, count=4, dout=0x01.
REQ-031 SHALL cover drain and wrap: pop 4 times, then push 0x2A, then pop -> dout order 0x01..0x04, then 0x2A taken from entry 0; empty=1 at the end.
REQ-032 SHALL cover simultaneous push and pop at the boundaries:
  - empty with push=pop=1, din=0x15 -> count=1, dout=0x15 next cycle.
  - full with push=pop=1 -> count=3, din dropped.
REQ-033 SHALL cover error flags with RVFIFO_W6_ERR_EN defined: push while full -> err_ovf=1 and stays 1 through 10 further idle cycles; pop while empty -> err_unf=1. Without the macro, both stay 0.
REQ-034 SHALL cover mid-operation reset: with 3 entries held, pulse rst for 1 cycle -> count=0, empty=1, dout=0; then push 0x3F -> dout=0x3F.

Source files
------------

// File: rtl/rvfifo_pkg.sv
// Shared defaults and pointer sizing helpers for the rvfifo family.
package rvfifo_pkg;

  localparam int RVFIFO_DEPTH_DEF = 4;
  localparam int RVFIFO_WIDTH_DEF = 6;

  // Pointer width for a power-of-two depth; depth 2 still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef logic [ptr_w(RVFIFO_DEPTH_DEF)-1:0] ptr_t;

endpackage

// File: rtl/rvfifo_ptr.sv
// Circular pointer: advances by one on inc and wraps from DEPTH-1 back to 0.
module rvfifo_ptr
  import rvfifo_pkg::*;
#(
  parameter int DEPTH = RVFIFO_DEPTH_DEF,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == LAST) ptr <= '0;
      else             ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rvfifo_w6.sv
// Flop-based first-word fall-through FIFO with registered empty/full.
// Optional sticky overflow/underflow flags are built when RVFIFO_W6_ERR_EN is defined.
module rvfifo_w6
  import rvfifo_pkg::*;
#(
  parameter int WIDTH = RVFIFO_WIDTH_DEF,
  parameter int DEPTH = RVFIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_ovf,
  output logic                     err_unf
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: a push is taken only when not full and a pop only when not
  // empty; a refused request has no effect beyond the optional error flags.
  logic          push_ok;
  logic          pop_ok;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  rvfifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .ptr (wr_ptr)
  );

  rvfifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count + CW'(push_ok) - CW'(pop_ok);
  end

`ifdef RVFIFO_W6_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (push && full) err_ovf <= 1'b1;
      if (pop && empty) err_unf <= 1'b1;
    end
  end
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

endmodule
